// File: rtl/seq_detect_cnt_pkg.sv
// Shared constants, FSM state type and sizing helper for the pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_detect_cnt_pkg;

    // Match-mode selector values for the OVERLAP parameter
    localparam bit MODE_OVERLAP    = 1'b1;
    localparam bit MODE_NONOVERLAP = 1'b0;

    // History occupancy: nothing held, partially filled, full window held
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2
    } fill_state_t;

    // Bits needed to hold a fill count in the range 0..pat_w
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_cnt_pat_shift_match.sv
// Serial history shift register with fill tracking; flags a pattern match on the incoming bit.
// Latency: match is combinational from x/en against registered history; history updates on posedge.
// Backpressure: none; every bit with en=1 is consumed, en=0 holds the history.
module pat_shift_match
    import seq_detect_cnt_pkg::*;
#(
    parameter int               PAT_W   = 2,
    parameter logic [PAT_W-1:0] PATTERN = 2'b01,
    parameter bit               OVERLAP = MODE_OVERLAP
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic x,
    output logic match
);

    localparam int FW = fill_w(PAT_W);
    // The oldest stored bit drops out of the window on the next shift, so only
    // PAT_W-1 bits of history ever take part in a comparison.
    localparam int HW = (PAT_W > 1) ? PAT_W - 1 : 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
    localparam logic [FW-1:0] FILL_ARM = FW'(PAT_W - 1);

    logic [HW-1:0]    hist;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_inc;
    fill_state_t      st;
    logic [PAT_W-1:0] window;
    logic             win_ok;

    // Candidate window: stored history with the new bit appended as LSB
    generate
        if (PAT_W == 1) begin : g_win_1
            assign window = x;
        end else begin : g_win_n
            assign window = {hist, x};
        end
    endgenerate

    // Enough bits held that the new bit completes a full window
    assign win_ok   = (st == ST_ARMED) || (fill == FILL_ARM);
    assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;
    assign match    = en && !clr && win_ok && (window == PATTERN);

    function automatic fill_state_t state_of(input logic [FW-1:0] f);
        if (f == '0)
            return ST_EMPTY;
        else if (f == FILL_MAX)
            return ST_ARMED;
        else
            return ST_FILLING;
    endfunction

    // History/fill FSM: clear beats everything, en qualifies each shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
            st   <= ST_EMPTY;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
            st   <= ST_EMPTY;
        end else if (en) begin
            if (match && (OVERLAP == MODE_NONOVERLAP)) begin
                hist <= '0;
                fill <= '0;
                st   <= ST_EMPTY;
            end else if (match) begin
                hist <= window[HW-1:0];
                fill <= FILL_MAX;
                st   <= ST_ARMED;
            end else begin
                hist <= window[HW-1:0];
                fill <= fill_inc;
                st   <= state_of(fill_inc);
            end
        end
    end

endmodule

// File: rtl/seq_detect_cnt.sv
// Serial pattern detector with registered match pulse, saturating match counter and sticky overflow.
// Latency: z and count update on the edge that consumes the final pattern bit (visible next cycle).
// Backpressure: none; en=0 stalls consumption, outputs hold (z drops to 0).
module seq_detect_cnt
    import seq_detect_cnt_pkg::*;
#(
    parameter int               PAT_W   = 2,
    parameter logic [PAT_W-1:0] PATTERN = 2'b01,
    parameter int               CNT_W   = 8,
    parameter bit               OVERLAP = MODE_OVERLAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr,
    output logic             z,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic match;

    pat_shift_match #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_pat (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .x     (x),
        .match (match)
    );

    // Registered pulse, saturating counter and sticky overflow on each match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z     <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            z     <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            z <= match;
            if (match) begin
                if (count == CNT_MAX)
                    ovf <= 1'b1;
                else
                    count <= count + 1'b1;
            end
        end
    end

endmodule

// File: doc/seq_detect_cnt.md
Name: seq_detect_cnt

Overview:
- Parametrised serial bit-pattern detector with an occurrence counter. It generalises the fixed 2-bit "01" Mealy detector to any pattern of width PAT_W.
- Overlapping or non-overlapping match mode is selectable by parameter. Adds input qualification, synchronous clear, and a saturating match counter with a sticky overflow flag.
- Sits on the serial input path. The registered z pulse and count feed the datapath and the status readback.

Parameters:
- PAT_W, 2, pattern length in bits (legal range 1..16).
- PATTERN, 2'b01, pattern to detect, PAT_W bits wide; MSB is the oldest bit received, LSB is the newest.
- CNT_W, 8, width of the match counter (legal range 1..32).
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history is discarded after each match.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; assertion clears all state immediately; release is synchronous to clk.
- en  in  1  bit-valid qualifier; x is consumed only on an edge where en=1.
- x  in  1  serial data bit.
- clr  in  1  synchronous clear of the counter, overflow flag, history and z.
- z  out  1  registered one-cycle match pulse.
- count  out  CNT_W  number of matches since reset or clr; saturating.
- ovf  out  1  sticky flag, set when a match occurs while count is already all-ones.

Behaviour:
- Reset values while rst=0: z=0, count=0, ovf=0, history=0, fill=0.
  - Reset mid-stream discards any partial match; no z pulse is produced from pre-reset bits.
- State:
  - hist: PAT_W-bit shift register.
  - fill: counter 0..PAT_W that saturates at PAT_W and counts valid bits held in hist.
  - These form the FSM, with states EMPTY (fill=0), FILLING (0<fill<PAT_W) and ARMED (fill=PAT_W).
- Match condition, evaluated combinationally at an edge with en=1:
  - Candidate window is {hist[PAT_W-2:0], x}. For PAT_W=1 the window is x alone.
  - match = (fill >= PAT_W-1) && (window == PATTERN).
- Update order at each posedge, highest priority first:
  1. clr=1: z<=0, count<=0, ovf<=0, hist<=0, fill<=0. Input x is ignored that cycle, even with en=1.
  2. en=0: hist, fill, count and ovf hold; z<=0.
  3. en=1, no match: hist<=window; fill<=min(fill+1, PAT_W); z<=0.
  4. en=1, match: z<=1.
     - If count != all-ones: count<=count+1. Otherwise count holds and ovf<=1.
     - OVERLAP=1: hist<=window; fill<=PAT_W.
     - OVERLAP=0: hist<=0; fill<=0 (returns to EMPTY).
- Latency: z rises in the cycle after the edge that consumed the final pattern bit. count updates on that same edge.
- z pulse width: one cycle per match. Back-to-back matches on consecutive en cycles (e.g. PAT_W=1) give z held high across those cycles.
- ovf persists until rst or clr. count never wraps.
- Gaps in en do not break a partial match; only consumed bits enter the history.
- Fully synchronous except rst. No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - the match-mode constants MODE_OVERLAP=1 and MODE_NONOVERLAP=0;
  - a fill-width helper function computing clog2(PAT_W+1).
- Sub-module pat_shift_match (params PAT_W, PATTERN, OVERLAP):
  - Owns hist and fill and produces the match strobe.
  - Inputs are clk, rst, en, clr and x.
- Top-level seq_detect_cnt owns the z register, the saturating counter and ovf.

Test Plan:
- Default params (01, overlap). Reset, then x=0,1,0,1,1,0,1 with en=1 every cycle -> z pulses after bits 2, 4 and 7; count=3; ovf=0.
- PAT_W=3, PATTERN=101, OVERLAP=1, x=1,0,1,0,1 -> z pulses after bits 3 and 5; count=2.
- Same stream with OVERLAP=0 -> z pulse after bit 3 only; count=1.
- Default params. Send x=0, then hold en=0 for 5 cycles with x toggling, then en=1 with x=1 -> exactly one z pulse, after the qualified 1; count=1.
- CNT_W=2, five "01" matches -> count reaches 3 after the third match and stays 3; ovf=1 after the fourth match; z still pulses on the 4th and 5th matches.
- Default params:
  - Drop rst asynchronously between a 0 and a 1 -> z=0 and count=0 immediately, and no pulse follows the 1.
  - Separately, assert clr together with en=1 and x=1 completing a match -> no z pulse; count=0; ovf=0.
